// File: rtl/mul_arbiter.sv
// Two-port round-robin front end for a shared multiplier.
// Ports: reqN valid/ready + operands, rspN valid/ready + shared result/err, mul_* side, flush, busy, ops_done.
module mul_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [XLEN-1:0]   req0_a_i,
  input  logic [XLEN-1:0]   req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [XLEN-1:0]   req1_a_i,
  input  logic [XLEN-1:0]   req1_b_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [2*XLEN-1:0] rsp_result_o,
  output logic              rsp_err_o,
  input  logic              flush_i,
  output logic              mul_req_o,
  output logic              mul_flush_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  input  logic              mul_ready_i,
  input  logic [2*XLEN-1:0] mul_result_i,
  output logic              busy_o,
  output logic [15:0]       ops_done_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_prio;
  logic              r_owner;
  logic              r_err;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_result;
  logic [15:0]       r_ops;

  logic            w_idle_ok;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_gnt;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic            w_zero;
  logic            w_tmo;
  logic            w_mul_flush;
  logic            w_rsp_hs;
  logic            w_calc_run;

  // Grants are combinational and held off during reset.
  assign w_idle_ok = (r_state == IDLE) && !flush_i && !rst_i;
  assign w_gnt0 = w_idle_ok && req0_valid_i
               && (!req1_valid_i || !r_prio);
  assign w_gnt1 = w_idle_ok && req1_valid_i
               && (!req0_valid_i || r_prio);
  assign w_gnt  = w_gnt0 || w_gnt1;

  assign w_sel_a = w_gnt1 ? req1_a_i : req0_a_i;
  assign w_sel_b = w_gnt1 ? req1_b_i : req0_b_i;
  assign w_zero  = (w_sel_a == '0) || (w_sel_b == '0);

  assign w_calc_run = (r_state == CALC) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_tmo       = 1'b0;
    w_mul_flush = 1'b0;
    w_rsp_hs    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gnt) w_next = w_zero ? RESP : CALC;
      end
      CALC: begin
        if (flush_i) begin
          w_mul_flush = 1'b1;
          w_next      = IDLE;
        end else if (mul_ready_i) begin
          w_next = RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_mul_flush = 1'b1;
          w_next      = RESP;
        end
      end
      RESP: begin
        if (flush_i) begin
          w_mul_flush = 1'b1;
          w_next      = IDLE;
        end else if (r_owner ? rsp1_ready_i : rsp0_ready_i) begin
          w_rsp_hs = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ops    <= '0;
    end else begin
      if (w_gnt) begin
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_owner <= w_gnt1;
        r_prio  <= w_gnt0;
        r_cnt   <= '0;
        if (w_zero) begin
          r_result <= '0;
          r_err    <= 1'b0;
        end
      end
      if (w_calc_run) begin
        r_cnt <= r_cnt + 1'b1;
        if (mul_ready_i) begin
          r_result <= mul_result_i;
          r_err    <= 1'b0;
        end else if (w_tmo) begin
          r_result <= '0;
          r_err    <= 1'b1;
        end
      end
      if (w_rsp_hs) r_ops <= r_ops + 16'd1;
    end
  end

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;
  assign rsp0_valid_o = (r_state == RESP) && !r_owner;
  assign rsp1_valid_o = (r_state == RESP) && r_owner;
  assign rsp_result_o = r_result;
  assign rsp_err_o    = r_err;
  assign mul_req_o    = (r_state == CALC);
  assign mul_flush_o  = w_mul_flush;
  assign mul_a_o      = r_a;
  assign mul_b_o      = r_b;
  assign busy_o       = (r_state != IDLE);
  assign ops_done_o   = r_ops;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter XLEN, default 32: operand width; result width is 2*XLEN.
REQ-002 Parameter TIMEOUT, default 15: maximum CALC cycles allowed while waiting for mul_ready_i.
REQ-003 clk_i  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1: reset, asynchronous and active-high.
REQ-005 req0_valid_i / req1_valid_i  in  1: requester 0/1 has an operation pending.
REQ-006 req0_ready_o / req1_ready_o  out  1: grant; an operation transfers when valid and ready are both high.
REQ-007 req0_a_i, req0_b_i, req1_a_i, req1_b_i  in  XLEN: unsigned operands per requester.
REQ-008 rsp0_valid_o / rsp1_valid_o  out  1: result available for the owning requester.
REQ-009 rsp0_ready_i / rsp1_ready_i  in  1: requester accepts the response.
REQ-010 rsp_result_o  out  2*XLEN: shared response data bus.
REQ-011 rsp_err_o  out  1: response is a timeout error; qualified by rspN_valid_o.
REQ-012 flush_i  in  1: abort the current operation.
REQ-013 mul_req_o  out  1: request to the multiplier; held high for the whole computation.
REQ-014 mul_flush_o  out  1: one-cycle abort pulse to the multiplier.
REQ-015 mul_a_o, mul_b_o  out  XLEN: registered operands driven to the multiplier.
REQ-016 mul_ready_i  in  1 and mul_result_i  in  2*XLEN: multiplier completion strobe and product.
REQ-017 busy_o  out  1: high in any state other than IDLE.
REQ-018 ops_done_o  out  16: count of completed responses; wraps from 0xFFFF to 0.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, CALC and RESP.
REQ-020 IDLE: if flush_i is low and at least one reqN_valid_i is high, the arbiter SHALL grant exactly one port in that cycle, using combinational reqN_ready_o.
REQ-021 Arbitration SHALL be round-robin: on contention the port selected by the prio bit wins; a lone valid port always wins; after any grant, prio points to the other port.
REQ-022 On a grant, the block SHALL register the operands into mul_a_o and mul_b_o and latch the owner. The next state SHALL be CALC, or RESP with result 0 and err 0 when either operand is zero (zero bypass: the multiplier is not requested).
REQ-023 reqN_ready_o SHALL be low in CALC and RESP, and low in IDLE while flush_i is high.
REQ-024 CALC: mul_req_o SHALL be 1, mul_a_o and mul_b_o SHALL be stable, and a timeout counter SHALL start at 0 on entry and increment each cycle.
REQ-025 In CALC, when mul_ready_i is high, the block SHALL capture mul_result_i into rsp_result_o, clear err and move to RESP.
REQ-026 In CALC, if the counter equals TIMEOUT-1 while mul_ready_i is low, the block SHALL set rsp_result_o to 0, set err to 1, pulse mul_flush_o for one cycle and move to RESP.
REQ-027 If mul_ready_i is high in the same cycle as the timeout condition, mul_ready_i SHALL win (normal result, no error).
REQ-028 RESP: the owner's rspN_valid_o SHALL be 1 and the other port's valid SHALL be 0. rsp_result_o and rsp_err_o SHALL be held until rspN_ready_i is high.
REQ-029 On the response handshake, the block SHALL increment ops_done_o and return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-030 mul_req_o SHALL be 0 in IDLE and RESP.
REQ-031 flush_i high in CALC or RESP SHALL take priority over every other event: pulse mul_flush_o that cycle, drop the operation with no response, leave ops_done_o unchanged, and move to IDLE next cycle.
REQ-032 Latency from grant to rspN_valid_o SHALL be 1 cycle for a zero bypass, or (cycles until mul_ready_i)+1 otherwise.

Reset
REQ-033 When rst_i is high, the block SHALL asynchronously enter IDLE and clear prio to 0 (port 0 first).
REQ-034 Reset SHALL clear the timeout counter, err, ops_done_o, rsp_result_o, mul_a_o and mul_b_o to 0.
REQ-035 During reset, every valid, ready, mul_req_o, mul_flush_o and busy_o output SHALL be 0.
REQ-036 A reset asserted mid-CALC SHALL abandon the operation with no response.

Verification
REQ-037 Port 0 requests a=3, b=5; multiplier asserts ready 6 cycles later with result 15 -> rsp0_valid_o with rsp_result_o=15, rsp_err_o=0; after handshake ops_done_o=1.
REQ-038 Both ports valid in IDLE after reset -> port 0 granted first, then port 1. With both still valid, grants alternate 0,1,0,1.
REQ-039 Port 1 requests a=0, b=0xFFFFFFFF -> mul_req_o never asserts; rsp1_valid_o one cycle after grant with result 0.
REQ-040 mul_ready_i held low with TIMEOUT=15 -> mul_flush_o pulses once after 15 CALC cycles; response has err=1 and result 0.
REQ-041 flush_i raised on the 3rd CALC cycle -> mul_flush_o pulse, IDLE next cycle, no rspN_valid_o, ops_done_o unchanged.
REQ-042 rsp0_ready_i held low for 4 cycles in RESP -> rsp0_valid_o and rsp_result_o stable, both req ready outputs low, busy_o=1 throughout.
